ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Two-port arbiter and cycle sequencer for the board's external asynchronous SRAM. It shares the single SRAM bus between the host register interface (read/write) and the MP3 data feeder (read-only). It generates chip-enable, output-enable and write-enable strobes with a parameterized access width, and returns one-cycle acknowledge pulses to each requester.

## Interface
- ADDR_WIDTH, 19: SRAM word address width.
- DATA_WIDTH, 16: SRAM data width.
- ACCESS_CYCLES, 2: strobe (nOE/nWE low) length in clocks; legal range 1..8.

- clk  in  1  system clock; all state changes on rising edge.
- nReset  in  1  asynchronous, active-low reset.
- host_req  in  1  host access request; held high until host_ack.
- host_write  in  1  1 = write, 0 = read; sampled with host_req at grant.
- host_addr  in  ADDR_WIDTH  host word address.
- host_wdata  in  DATA_WIDTH  host write data.
- host_ack  out  1  one-cycle completion pulse.
- host_rdata  out  DATA_WIDTH  last host read data, registered.
- mp3_req  in  1  feeder read request; held high until mp3_ack.
- mp3_addr  in  ADDR_WIDTH  feeder word address.
- mp3_ack  out  1  one-cycle completion pulse.
- mp3_rdata  out  DATA_WIDTH  last feeder read data, registered.
- ram_addr  out  ADDR_WIDTH  SRAM address.
- ram_wdata  out  DATA_WIDTH  SRAM write data.
- ram_oe  out  1  1 = drive ram_wdata onto the SRAM data pins (pad tristate control).
- ram_rdata  in  DATA_WIDTH  SRAM data pins, input side.
- ram_nCE, ram_nOE, ram_nWE  out  1 each  active-low SRAM strobes.

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD.
- IDLE:
  - All strobes high; ram_oe low.
  - On any req: pick a winner, latch its address, direction and write data into ram_addr/ram_wdata and an internal owner flag, then go to SETUP.
  - mp3 is always a read.
- SETUP (1 cycle): ram_nCE low. For writes, ram_oe high. nOE and nWE stay high.
- STROBE (ACCESS_CYCLES cycles):
  - Read: ram_nOE low. Write: ram_nWE low.
  - A 3-bit down-counter is loaded with ACCESS_CYCLES-1 on entry. The FSM leaves STROBE when the counter reaches 0.
  - Read data is captured from ram_rdata into the owner's rdata register on the final STROBE clock edge.
- HOLD (1 cycle):
  - nOE and nWE high; ram_nCE low; address held; ram_oe held for writes.
  - Owner's ack high.
  - Next state is IDLE.
- Arbitration is evaluated only in IDLE. A request arriving mid-access waits and is never dropped.
- Requesters must keep address, data and write stable from req until ack, and deassert req in the cycle after ack. A req still high in IDLE after ack is a new request.
- The non-owner's ack and rdata are never touched.

## Timing
- With req sampled high in IDLE at cycle 0: SETUP at cycle 1, STROBE at cycles 2..1+ACCESS_CYCLES, HOLD/ack at cycle 2+ACCESS_CYCLES.
- Default ack latency is 4 cycles.
- Minimum back-to-back period per access is ACCESS_CYCLES+3 cycles.
- rdata is valid in the ack cycle and held until that port's next read completes.
- Address is stable from SETUP through HOLD, giving one cycle of setup and one of hold around the strobe.
- ram_oe is never high while ram_nOE is low.
- Reset values: FSM IDLE; ram_nCE/nOE/nWE = 1; ram_oe = 0; ram_addr, ram_wdata, host_rdata, mp3_rdata = 0; host_ack, mp3_ack = 0; priority pointer = host.
- Reset mid-access: strobes go high and ram_oe goes low immediately, asynchronously. No ack is issued for the aborted access.
- An ACCESS_CYCLES value outside 1..8 is a configuration error; the simulation check reports it with $error.

## Configuration
- ARBITER_ROUND_ROBIN_EN defined:
  - A 1-bit priority pointer flips to the other port after every grant.
  - When both ports request in IDLE, the pointer's port wins.
  - The pointer has no effect when only one port requests.
- Not defined: fixed priority, host always wins over mp3. The pointer register is not built.

## Test plan
- Host write, addr 0x12345, data 0xBEEF -> SETUP with ram_oe=1, nWE low for 2 cycles, nOE stays high, host_ack at cycle 4, mp3_ack stays 0.
- mp3 read, addr 0x00010, SRAM model returns 0xA55A -> nOE low for 2 cycles, mp3_ack at cycle 4, mp3_rdata = 0xA55A, host_rdata unchanged.
- host_req and mp3_req held continuously, without the macro -> four consecutive host grants, no mp3 ack.
- Same stimulus with ARBITER_ROUND_ROBIN_EN -> grants alternate host, mp3, host, mp3, each spaced 5 cycles apart.
- nReset pulsed low during the second STROBE cycle of a write -> nWE, nCE and ram_oe deassert in the same cycle, no ack, FSM in IDLE after release.
- ACCESS_CYCLES=1 with back-to-back host reads -> ack every 4 cycles, nOE low exactly 1 cycle per access.

Source files
------------

// File: rtl/ram_arbiter.sv
`timescale 1ns/1ps
// ram_arbiter
// Two-port arbiter and cycle sequencer for the external asynchronous SRAM.
// The host register interface (read/write) and the MP3 data feeder
// (read-only) share one SRAM bus. Each access runs IDLE -> SETUP ->
// STROBE (ACCESS_CYCLES clocks) -> HOLD, and the owner gets a one-cycle ack
// in HOLD.
//
// Parameters:
//   ADDR_WIDTH    SRAM word address width
//   DATA_WIDTH    SRAM data width
//   ACCESS_CYCLES nOE/nWE low time in clocks, legal 1..8
//
// Ports:
//   clk, nReset                 clock, asynchronous active-low reset
//   host_req/write/addr/wdata   host request (held until host_ack)
//   host_ack, host_rdata        host completion pulse, last host read data
//   mp3_req/addr                feeder read request (held until mp3_ack)
//   mp3_ack, mp3_rdata          feeder completion pulse, last feeder read data
//   ram_addr, ram_wdata         SRAM address and write data
//   ram_oe                      1 = drive ram_wdata onto the SRAM data pins
//   ram_rdata                   SRAM data pins, input side
//   ram_nCE, ram_nOE, ram_nWE   active-low SRAM strobes
//
// Build option:
//   ARBITER_ROUND_ROBIN_EN  defined: round-robin between the two ports via a
//                           1-bit priority pointer. Undefined: host always
//                           wins over mp3.
module ram_arbiter #(
   parameter int unsigned ADDR_WIDTH    = 19,
   parameter int unsigned DATA_WIDTH    = 16,
   parameter int unsigned ACCESS_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  nReset,
   input  logic                  host_req,
   input  logic                  host_write,
   input  logic [ADDR_WIDTH-1:0] host_addr,
   input  logic [DATA_WIDTH-1:0] host_wdata,
   output logic                  host_ack,
   output logic [DATA_WIDTH-1:0] host_rdata,
   input  logic                  mp3_req,
   input  logic [ADDR_WIDTH-1:0] mp3_addr,
   output logic                  mp3_ack,
   output logic [DATA_WIDTH-1:0] mp3_rdata,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_wdata,
   output logic                  ram_oe,
   input  logic [DATA_WIDTH-1:0] ram_rdata,
   output logic                  ram_nCE,
   output logic                  ram_nOE,
   output logic                  ram_nWE
);

   typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

   localparam logic [2:0] CNT_LOAD = 3'(ACCESS_CYCLES - 1);

   state_t     state;
   logic       owner_mp3;
   logic       is_write;
   logic [2:0] cnt;
   logic       any_req;
   logic       grant_mp3;

`ifdef ARBITER_ROUND_ROBIN_EN
   logic       prio_mp3;

   // The pointer only matters when both ports are requesting.
   always_comb begin
      any_req   = host_req | mp3_req;
      grant_mp3 = mp3_req & (~host_req | prio_mp3);
   end
`else
   always_comb begin
      any_req   = host_req | mp3_req;
      grant_mp3 = mp3_req & ~host_req;
   end
`endif

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         state      <= IDLE;
         owner_mp3  <= 1'b0;
         is_write   <= 1'b0;
         cnt        <= '0;
         ram_addr   <= '0;
         ram_wdata  <= '0;
         ram_oe     <= 1'b0;
         ram_nCE    <= 1'b1;
         ram_nOE    <= 1'b1;
         ram_nWE    <= 1'b1;
         host_ack   <= 1'b0;
         mp3_ack    <= 1'b0;
         host_rdata <= '0;
         mp3_rdata  <= '0;
`ifdef ARBITER_ROUND_ROBIN_EN
         prio_mp3   <= 1'b0;
`endif
      end else begin
         host_ack <= 1'b0;
         mp3_ack  <= 1'b0;
         case (state)
            IDLE: begin
               if (any_req) begin
                  owner_mp3 <= grant_mp3;
                  is_write  <= ~grant_mp3 & host_write;
                  ram_addr  <= grant_mp3 ? mp3_addr : host_addr;
                  if (!grant_mp3)
                     ram_wdata <= host_wdata;
                  ram_nCE   <= 1'b0;
                  ram_oe    <= ~grant_mp3 & host_write;
                  state     <= SETUP;
`ifdef ARBITER_ROUND_ROBIN_EN
                  prio_mp3  <= ~prio_mp3;
`endif
               end
            end
            SETUP: begin
               cnt     <= CNT_LOAD;
               ram_nOE <= is_write;
               ram_nWE <= ~is_write;
               state   <= STROBE;
            end
            STROBE: begin
               if (cnt == 3'd0) begin
                  // Final strobe edge: capture read data and raise the ack so
                  // it is visible during HOLD.
                  ram_nOE <= 1'b1;
                  ram_nWE <= 1'b1;
                  if (!is_write) begin
                     if (owner_mp3)
                        mp3_rdata <= ram_rdata;
                     else
                        host_rdata <= ram_rdata;
                  end
                  if (owner_mp3)
                     mp3_ack <= 1'b1;
                  else
                     host_ack <= 1'b1;
                  state <= HOLD;
               end else begin
                  cnt <= cnt - 3'd1;
               end
            end
            HOLD: begin
               ram_nCE <= 1'b1;
               ram_oe  <= 1'b0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Configuration sanity check; the strobe counter is only 3 bits wide.
   always_ff @(posedge clk) begin
      assert (ACCESS_CYCLES >= 1 && ACCESS_CYCLES <= 8)
         else $error("ram_arbiter: ACCESS_CYCLES=%0d outside 1..8", ACCESS_CYCLES);
   end

endmodule

// File: tb/tb_ram_arbiter.sv
`timescale 1ns/1ps
module tb_ram_arbiter;

   localparam int unsigned AW = 19;
   localparam int unsigned DW = 16;
   localparam int unsigned AC = 2;

   logic          clk = 1'b0;
   logic          nReset = 1'b0;

   // Main instance (ACCESS_CYCLES = 2)
   logic          host_req = 1'b0, host_write = 1'b0;
   logic [AW-1:0] host_addr = '0;
   logic [DW-1:0] host_wdata = '0;
   logic          host_ack;
   logic [DW-1:0] host_rdata;
   logic          mp3_req = 1'b0;
   logic [AW-1:0] mp3_addr = '0;
   logic          mp3_ack;
   logic [DW-1:0] mp3_rdata;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata;
   logic          ram_oe;
   logic [DW-1:0] ram_rdata;
   logic          ram_nCE, ram_nOE, ram_nWE;

   // Second instance (ACCESS_CYCLES = 1)
   logic          h1_req = 1'b0, h1_write = 1'b0;
   logic [AW-1:0] h1_addr = '0;
   logic [DW-1:0] h1_wdata = '0;
   logic          host_ack1;
   logic [DW-1:0] host_rdata1;
   logic          m1_req = 1'b0;
   logic [AW-1:0] m1_addr = '0;
   logic          mp3_ack1;
   logic [DW-1:0] mp3_rdata1;
   logic [AW-1:0] ram_addr1;
   logic [DW-1:0] ram_wdata1;
   logic          ram_oe1;
   logic [DW-1:0] ram_rdata1;
   logic          ram_nCE1, ram_nOE1, ram_nWE1;

   int unsigned cyc = 0;
   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   int unsigned noe1_cnt = 0;
   logic [DW-1:0] exp_h = '0;
   logic [DW-1:0] exp_m = '0;

   typedef struct {
      bit          mp3;
      bit          write;
      logic [15:0] rdata;
      int unsigned due;
   } exp_t;

   exp_t sb[$];
   exp_t sb1[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // SRAM model: fixed pattern at 0x00010, otherwise low address bits ^ 0x1234
   function automatic logic [DW-1:0] sram_data(input logic [AW-1:0] a);
      logic [DW-1:0] d;
      if (a == 19'h00010) d = 16'hA55A;
      else                d = a[15:0] ^ 16'h1234;
      return d;
   endfunction

   assign ram_rdata  = sram_data(ram_addr);
   assign ram_rdata1 = sram_data(ram_addr1);

   ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ACCESS_CYCLES(AC)) dut (
      .clk(clk), .nReset(nReset),
      .host_req(host_req), .host_write(host_write), .host_addr(host_addr),
      .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
      .mp3_req(mp3_req), .mp3_addr(mp3_addr), .mp3_ack(mp3_ack), .mp3_rdata(mp3_rdata),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_oe(ram_oe), .ram_rdata(ram_rdata),
      .ram_nCE(ram_nCE), .ram_nOE(ram_nOE), .ram_nWE(ram_nWE)
   );

   ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ACCESS_CYCLES(1)) dut1 (
      .clk(clk), .nReset(nReset),
      .host_req(h1_req), .host_write(h1_write), .host_addr(h1_addr),
      .host_wdata(h1_wdata), .host_ack(host_ack1), .host_rdata(host_rdata1),
      .mp3_req(m1_req), .mp3_addr(m1_addr), .mp3_ack(mp3_ack1), .mp3_rdata(mp3_rdata1),
      .ram_addr(ram_addr1), .ram_wdata(ram_wdata1), .ram_oe(ram_oe1), .ram_rdata(ram_rdata1),
      .ram_nCE(ram_nCE1), .ram_nOE(ram_nOE1), .ram_nWE(ram_nWE1)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor for the main instance: every ack pops one expected completion.
   always @(negedge clk) begin : mon
      exp_t e;
      if (host_ack || mp3_ack) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_ack: host_ack=%0b mp3_ack=%0b, expected no ack (cycle %0d)",
                     host_ack, mp3_ack, cyc);
         end else begin
            e = sb.pop_front();
            chk("ack_port", 32'({host_ack, mp3_ack}), e.mp3 ? 32'd1 : 32'd2);
            chk("ack_cycle", cyc, e.due);
            if (!e.write) begin
               if (e.mp3) exp_m = e.rdata;
               else       exp_h = e.rdata;
            end
            chk("host_rdata", 32'(host_rdata), 32'(exp_h));
            chk("mp3_rdata", 32'(mp3_rdata), 32'(exp_m));
         end
      end
   end

   // Monitor for the ACCESS_CYCLES=1 instance.
   always @(negedge clk) begin : mon1
      exp_t e;
      if (nReset && !ram_nOE1) noe1_cnt++;
      if (host_ack1 || mp3_ack1) begin
         if (sb1.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_ack1: host_ack1=%0b mp3_ack1=%0b, expected no ack (cycle %0d)",
                     host_ack1, mp3_ack1, cyc);
         end else begin
            e = sb1.pop_front();
            chk("ack1_port", 32'({host_ack1, mp3_ack1}), e.mp3 ? 32'd1 : 32'd2);
            chk("ack1_cycle", cyc, e.due);
            chk("host_rdata1", 32'(host_rdata1), 32'(e.rdata));
            chk("noe1_low_cycles", noe1_cnt, 32'd1);
         end
         noe1_cnt = 0;
      end
   end

   // One complete access on the main instance, checking strobes every cycle.
   task automatic access(input bit mp3, input bit wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input logic [DW-1:0] exp_rd);
      exp_t e;
      bit   strobe;
      tick();
      if (mp3) begin
         mp3_addr = a;
         mp3_req  = 1'b1;
      end else begin
         host_addr  = a;
         host_wdata = wd;
         host_write = wr;
         host_req   = 1'b1;
      end
      e.mp3 = mp3; e.write = wr; e.rdata = exp_rd; e.due = cyc + AC + 2;
      sb.push_back(e);
      for (int k = 1; k <= int'(AC) + 2; k++) begin
         tick();
         @(negedge clk);
         strobe = (k >= 2) && (k <= int'(AC) + 1);
         chk("nCE", 32'(ram_nCE), 32'd0);
         chk("nOE", 32'(ram_nOE), 32'(!(strobe && !wr)));
         chk("nWE", 32'(ram_nWE), 32'(!(strobe && wr)));
         chk("ram_oe", 32'(ram_oe), 32'(wr));
         chk("ram_addr", 32'(ram_addr), 32'(a));
         if (wr) chk("ram_wdata", 32'(ram_wdata), 32'(wd));
      end
      tick();
      host_req = 1'b0;
      mp3_req  = 1'b0;
      @(negedge clk);
      chk("idle_nCE", 32'(ram_nCE), 32'd1);
      chk("idle_oe", 32'(ram_oe), 32'd0);
   endtask

   initial begin : stim
      int unsigned c;
      exp_t e;

      // Reset values
      #12;
      chk("rst_nCE", 32'(ram_nCE), 32'd1);
      chk("rst_nOE", 32'(ram_nOE), 32'd1);
      chk("rst_nWE", 32'(ram_nWE), 32'd1);
      chk("rst_oe", 32'(ram_oe), 32'd0);
      chk("rst_addr", 32'(ram_addr), 32'd0);
      chk("rst_wdata", 32'(ram_wdata), 32'd0);
      chk("rst_host_rdata", 32'(host_rdata), 32'd0);
      chk("rst_mp3_rdata", 32'(mp3_rdata), 32'd0);
      chk("rst_acks", 32'({host_ack, mp3_ack}), 32'd0);
      chk("rst1_strobes", 32'({ram_nCE1, ram_nOE1, ram_nWE1, ram_oe1}), 32'hE);
      #10 nReset = 1'b1;

      // Host write, then mp3 read, then host read
      access(1'b0, 1'b1, 19'h12345, 16'hBEEF, 16'h0000);
      access(1'b1, 1'b0, 19'h00010, 16'h0000, 16'hA55A);
      access(1'b0, 1'b0, 19'h00200, 16'h0000, 16'h1034);

      // Reset during the second STROBE cycle of a write
      tick();
      host_addr = 19'h00444; host_wdata = 16'h1357; host_write = 1'b1; host_req = 1'b1;
      tick();            // SETUP
      tick();            // STROBE 1
      @(negedge clk);
      chk("pre_rst_nWE", 32'(ram_nWE), 32'd0);
      tick();            // STROBE 2
      nReset = 1'b0;
      host_req = 1'b0;
      exp_h = '0;
      exp_m = '0;
      #1;
      chk("arst_nWE", 32'(ram_nWE), 32'd1);
      chk("arst_nCE", 32'(ram_nCE), 32'd1);
      chk("arst_oe", 32'(ram_oe), 32'd0);
      chk("arst_host_rdata", 32'(host_rdata), 32'd0);
      chk("arst_mp3_rdata", 32'(mp3_rdata), 32'd0);
      tick();
      tick();
      nReset = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      @(negedge clk);
      chk("post_rst_nCE", 32'(ram_nCE), 32'd1);

      // Both ports requesting continuously
      tick();
      host_addr = 19'h00100; host_write = 1'b0; mp3_addr = 19'h00300;
      host_req = 1'b1; mp3_req = 1'b1;
      c = cyc;
`ifdef ARBITER_ROUND_ROBIN_EN
      for (int i = 0; i < 4; i++) begin
         e.mp3 = (i % 2) == 1; e.write = 1'b0;
         e.rdata = e.mp3 ? 16'h1134 : 16'h1334;
         e.due = c + 4 + 5 * i;
         sb.push_back(e);
      end
      while (cyc < c + 20) tick();
      host_req = 1'b0;
      mp3_req  = 1'b0;
`else
      for (int i = 0; i < 4; i++) begin
         e.mp3 = 1'b0; e.write = 1'b0; e.rdata = 16'h1334; e.due = c + 4 + 5 * i;
         sb.push_back(e);
      end
      e.mp3 = 1'b1; e.write = 1'b0; e.rdata = 16'h1134; e.due = c + 24;
      sb.push_back(e);
      while (cyc < c + 20) tick();
      host_req = 1'b0;
      while (cyc < c + 25) tick();
      mp3_req = 1'b0;
`endif
      for (int i = 0; i < 4; i++) tick();

      // ACCESS_CYCLES=1 instance: back-to-back host reads
      tick();
      h1_addr = 19'h00005; h1_write = 1'b0; h1_req = 1'b1;
      c = cyc;
      for (int i = 0; i < 3; i++) begin
         e.mp3 = 1'b0; e.write = 1'b0; e.rdata = 16'h1231; e.due = c + 3 + 4 * i;
         sb1.push_back(e);
      end
      while (cyc < c + 12) tick();
      h1_req = 1'b0;
      for (int i = 0; i < 4; i++) tick();

      @(negedge clk);
      chk("sb_drained", 32'(sb.size()), 32'd0);
      chk("sb1_drained", 32'(sb1.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
